// File: rtl/ram_uart_ctrl_pkg.sv
// Shared definitions for the RAM1/UART bus controller: FSM states, UART register map
// and the bit layout of the UART status word.
package ram_uart_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_RX_STROBE    = 4'd1,
    ST_RX_DONE      = 4'd2,
    ST_RAM_RD       = 4'd3,
    ST_RAM_WR       = 4'd4,
    ST_RAM_WR_HOLD  = 4'd5,
    ST_TX_SETUP     = 4'd6,
    ST_TX_STROBE    = 4'd7,
    ST_TX_HOLD      = 4'd8,
    ST_TX_WAIT_TBRE = 4'd9,
    ST_TX_WAIT_TSRE = 4'd10,
    ST_RESP         = 4'd11
  } state_t;

  localparam int UART_DATA_ADDR_DEF = 'hBF00;
  localparam int UART_STAT_ADDR_DEF = 'hBF01;

  localparam int STAT_TXRDY  = 0;
  localparam int STAT_RXAV   = 1;
  localparam int STAT_RXFULL = 2;

endpackage

// File: rtl/ram_uart_ctrl_if.sv
// CPU-side request/acknowledge bundle between the MEM stage and the bus controller.
interface ram_uart_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (output req, wr, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, wr, addr, wdata, output ack, rdata, busy);

endinterface

// File: rtl/ram_uart_ctrl_rx_fifo.sv
// Synchronous FIFO buffering bytes drained from the UART receiver until the CPU pops them.
module ram_uart_ctrl_rx_fifo #(
  parameter int DATA_W    = 16,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    dout,
  output logic [FIFO_LOG2:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2 ** FIFO_LOG2;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_head;
  logic [FIFO_LOG2-1:0] r_tail;
  logic [FIFO_LOG2:0]   r_count;
  logic                 w_doPush;
  logic                 w_doPop;

  assign full     = (r_count == (FIFO_LOG2+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_head];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_tail <= r_tail + 1'b1;
      if (w_doPop)  r_head <= r_head + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (!w_doPush && w_doPop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_tail] <= din;
  end

endmodule

// File: rtl/ram_uart_ctrl.sv
// Shared RAM1/UART data bus controller: serves CPU req/ack transactions and drains the
// UART receiver into an RX FIFO whenever the bus is idle.
module ram_uart_ctrl
  import ram_uart_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int FIFO_LOG2      = 4,
  parameter int RAM_WAIT       = 2,
  parameter int UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter int UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ram_uart_ctrl_if.slave      cpu,
  output logic [ADDR_W-1:0]   ram_addr,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic                ram_en,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                rdn,
  output logic                wrn,
  input  logic                data_ready,
  input  logic                tbre,
  input  logic                tsre,
  output logic [FIFO_LOG2:0]  rx_count
);

  localparam int CNT_W = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

  state_t              r_state;
  state_t              w_nextState;
  logic [CNT_W-1:0]    r_waitCnt;
  logic                w_waitDone;
  logic                w_isStrobe;
  logic                w_accept;
  logic                w_busDrive;
  logic                w_ack;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_hitData;
  logic                w_hitStat;
  logic [DATA_W-1:0]   w_fifoDout;
  logic [DATA_W-1:0]   w_statWord;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_rxByte;
  logic                r_popPending;

  assign w_hitData  = (cpu.addr == ADDR_W'(UART_DATA_ADDR));
  assign w_hitStat  = (cpu.addr == ADDR_W'(UART_STAT_ADDR));
  assign w_waitDone = (r_waitCnt == CNT_W'(RAM_WAIT - 1));
  assign ram_data   = w_busDrive ? r_wdata : 'z;
  assign cpu.ack    = w_ack;
  assign cpu.rdata  = r_rdata;
  assign cpu.busy   = (r_state != ST_IDLE);

  always_comb begin
    w_statWord              = '0;
    w_statWord[STAT_TXRDY]  = tbre & tsre;
    w_statWord[STAT_RXAV]   = !w_empty;
    w_statWord[STAT_RXFULL] = w_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) r_waitCnt <= '0;
      else if (w_isStrobe)        r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  // RX draining wins over CPU requests; a full FIFO leaves the byte in the UART.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_isStrobe  = 1'b0;
    w_busDrive  = 1'b0;
    w_ack       = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    ram_en      = 1'b1;
    ram_oe      = 1'b1;
    ram_we      = 1'b1;
    rdn         = 1'b1;
    wrn         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (data_ready && !w_full) begin
          w_nextState = ST_RX_STROBE;
        end else if (cpu.req) begin
          w_accept = 1'b1;
          if (w_hitStat)      w_nextState = ST_RESP;
          else if (w_hitData) w_nextState = cpu.wr ? ST_TX_SETUP : ST_RESP;
          else                w_nextState = cpu.wr ? ST_RAM_WR : ST_RAM_RD;
        end
      end
      ST_RX_STROBE: begin
        rdn        = 1'b0;
        w_isStrobe = 1'b1;
        if (w_waitDone) w_nextState = ST_RX_DONE;
      end
      ST_RX_DONE: begin
        w_push      = 1'b1;
        w_nextState = ST_IDLE;
      end
      ST_RAM_RD: begin
        ram_en     = 1'b0;
        ram_oe     = 1'b0;
        w_isStrobe = 1'b1;
        if (w_waitDone) w_nextState = ST_RESP;
      end
      ST_RAM_WR: begin
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        w_busDrive = 1'b1;
        w_isStrobe = 1'b1;
        if (w_waitDone) w_nextState = ST_RAM_WR_HOLD;
      end
      ST_RAM_WR_HOLD: begin
        ram_en      = 1'b0;
        w_busDrive  = 1'b1;
        w_nextState = ST_RESP;
      end
      ST_TX_SETUP: begin
        w_busDrive  = 1'b1;
        w_nextState = ST_TX_STROBE;
      end
      ST_TX_STROBE: begin
        wrn        = 1'b0;
        w_busDrive = 1'b1;
        w_isStrobe = 1'b1;
        if (w_waitDone) w_nextState = ST_TX_HOLD;
      end
      ST_TX_HOLD: begin
        w_busDrive  = 1'b1;
        w_nextState = ST_TX_WAIT_TBRE;
      end
      ST_TX_WAIT_TBRE: if (tbre) w_nextState = ST_TX_WAIT_TSRE;
      ST_TX_WAIT_TSRE: if (tsre) w_nextState = ST_RESP;
      ST_RESP: begin
        w_ack       = 1'b1;
        w_pop       = r_popPending && !w_empty;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // UART register reads are resolved at accept so rdata is already valid during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr     <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_rxByte     <= '0;
      r_popPending <= 1'b0;
    end else begin
      if (w_accept) begin
        ram_addr     <= cpu.addr;
        r_wdata      <= cpu.wdata;
        r_popPending <= w_hitData && !cpu.wr;
        if (!cpu.wr && w_hitStat)      r_rdata <= w_statWord;
        else if (!cpu.wr && w_hitData) r_rdata <= w_empty ? '0 : w_fifoDout;
      end
      if (r_state == ST_RAM_RD && w_waitDone)    r_rdata  <= ram_data;
      if (r_state == ST_RX_STROBE && w_waitDone) r_rxByte <= ram_data[7:0];
    end
  end

  ram_uart_ctrl_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_rxFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (DATA_W'(r_rxByte)),
    .dout  (w_fifoDout),
    .count (rx_count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_ram_uart_ctrl.sv
// Self-checking bench for ram_uart_ctrl with RAM1 and UART device models on the shared bus.
module tb_ram_uart_ctrl;
  import ram_uart_ctrl_pkg::*;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int FIFO_LOG2 = 4;
  localparam int RAM_WAIT  = 2;
  localparam int DEPTH     = 16;
  localparam logic [ADDR_W-1:0] DATA_ADDR = 18'h0BF00;
  localparam logic [ADDR_W-1:0] STAT_ADDR = 18'h0BF01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_uart_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpuBus ();

  wire  [DATA_W-1:0]  ramData;
  logic [ADDR_W-1:0]  ramAddr;
  logic               ramEn, ramOe, ramWe, rdn, wrn;
  logic               dataReady, tbre, tsre;
  logic [FIFO_LOG2:0] rxCount;

  ram_uart_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_LOG2(FIFO_LOG2), .RAM_WAIT(RAM_WAIT),
    .UART_DATA_ADDR('hBF00), .UART_STAT_ADDR('hBF01)
  ) dut (
    .clk(clk), .rst(rst), .cpu(cpuBus),
    .ram_addr(ramAddr), .ram_data(ramData), .ram_en(ramEn), .ram_oe(ramOe), .ram_we(ramWe),
    .rdn(rdn), .wrn(wrn), .data_ready(dataReady), .tbre(tbre), .tsre(tsre), .rx_count(rxCount)
  );

  // Device models: RAM1 array, UART RX byte source, UART TX with delayed empty flags
  logic [DATA_W-1:0] ramMem [0:1023];
  logic [7:0]        injBuf [0:255];
  logic [7:0]        injWr = 8'd0;
  logic [7:0]        injRd = 8'd0;
  logic [7:0]        uartHead;
  logic              zProbe = 1'b0;
  logic              tbreForceLow = 1'b0;
  logic              tbDrive;
  logic [DATA_W-1:0] tbVal;
  int txTimer = 0, weLen = 0, weLast = 0, rdnLen = 0, rdnLast = 0, rdnPulses = 0;
  int wrnLen = 0, wrnLast = 0, txCount = 0;
  logic [DATA_W-1:0] txByte = '0;

  assign uartHead  = injBuf[injRd];
  assign dataReady = (injRd != injWr);
  assign tbre      = !tbreForceLow && (txTimer == 0 || txTimer >= 6);
  assign tsre      = (txTimer == 0 || txTimer >= 9);

  always_comb begin
    tbDrive = 1'b0;
    tbVal   = '0;
    if (!ramEn && !ramOe) begin
      tbDrive = 1'b1;
      tbVal   = ramMem[ramAddr[9:0]];
    end else if (!rdn) begin
      tbDrive = 1'b1;
      tbVal   = {8'hC3, uartHead};
    end else if (zProbe) begin
      tbDrive = 1'b1;
    end
  end
  assign ramData = tbDrive ? tbVal : 'z;

  // Strobe monitor: pulse widths, RAM write capture, UART byte consumption, TX timing
  always @(negedge clk) begin
    if (!ramWe) weLen++;
    else if (weLen != 0) begin
      weLast = weLen; weLen = 0;
      ramMem[ramAddr[9:0]] = ramData;
    end
    if (!rdn) rdnLen++;
    else if (rdnLen != 0) begin
      rdnLast = rdnLen; rdnLen = 0; rdnPulses++;
      if (injRd != injWr) injRd = injRd + 8'd1;
    end
    if (!wrn) begin
      wrnLen++; txByte = ramData;
    end else if (wrnLen != 0) begin
      wrnLast = wrnLen; wrnLen = 0; txCount++; txTimer = 1;
    end else if (txTimer != 0 && txTimer < 20) txTimer++;
  end

  int passCnt = 0;
  int checkCnt = 0;
  logic [DATA_W-1:0] expMem [int];
  logic [7:0] expRx [$];

  task automatic doTxn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output logic [DATA_W-1:0] rd, output int lat);
    bit got = 0;
    rd = '0; lat = -1;
    @(negedge clk);
    cpuBus.req = 1'b1; cpuBus.wr = w; cpuBus.addr = a; cpuBus.wdata = d;
    for (int e = 1; e <= 300 && !got; e++) begin
      @(posedge clk); #1;
      if (cpuBus.ack) begin
        got = 1; rd = cpuBus.rdata; lat = e; cpuBus.req = 1'b0;
      end
    end
    cpuBus.req = 1'b0;
    if (!got) begin
      checkCnt++;
      $display("[TB] FAIL txn_timeout: no ack for addr %h (wr=%0d) within 300 cycles", a, w);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic injectByte(input logic [7:0] b);
    injBuf[injWr] = b;
    injWr = injWr + 8'd1;
    expRx.push_back(b);
  endtask

  task automatic waitRxCount(input int n);
    for (int i = 0; i < 300 && rxCount != (FIFO_LOG2+1)'(n); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    zProbe = 1'b1; #1;
    checkCnt++;
    if ({cpuBus.ack, cpuBus.busy, ramEn, ramOe, ramWe, rdn, wrn} !== 7'b0011111)
      $display("[TB] FAIL reset_strobes: got %b expected %b",
               {cpuBus.ack, cpuBus.busy, ramEn, ramOe, ramWe, rdn, wrn}, 7'b0011111);
    else passCnt++;
    checkCnt++;
    if ({cpuBus.rdata, ramAddr, rxCount} !== '0)
      $display("[TB] FAIL reset_regs: rdata %h addr %h rx_count %0d expected all zero",
               cpuBus.rdata, ramAddr, rxCount);
    else passCnt++;
    checkCnt++;
    if (ramData !== 16'h0000) $display("[TB] FAIL reset_bus_z: bus %h expected undriven", ramData);
    else passCnt++;
    zProbe = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_write_read();
    logic [DATA_W-1:0] rd, d;
    int lat, a;
    int addrs [$];
    doTxn(1'b1, 18'h00010, 16'h1234, rd, lat);
    expMem[16] = 16'h1234;
    checkCnt++;
    if (lat !== 4) $display("[TB] FAIL ram_wr_latency: got %0d expected 4", lat); else passCnt++;
    checkCnt++;
    if (weLast !== RAM_WAIT) $display("[TB] FAIL ram_we_width: got %0d expected %0d", weLast, RAM_WAIT);
    else passCnt++;
    doTxn(1'b0, 18'h00010, 16'h0000, rd, lat);
    checkCnt++;
    if (lat !== 3) $display("[TB] FAIL ram_rd_latency: got %0d expected 3", lat); else passCnt++;
    checkCnt++;
    if (rd !== 16'h1234) $display("[TB] FAIL ram_rd_data: got %h expected 1234", rd); else passCnt++;
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 1023));
      d = 16'($urandom);
      doTxn(1'b1, 18'(a), d, rd, lat);
      expMem[a] = d;
      addrs.push_back(a);
    end
    foreach (addrs[i]) begin
      doTxn(1'b0, 18'(addrs[i]), 16'h0000, rd, lat);
      checkCnt++;
      if (rd !== expMem[addrs[i]])
        $display("[TB] FAIL ram_rand_rd: addr %h got %h expected %h", addrs[i], rd, expMem[addrs[i]]);
      else passCnt++;
    end
  endtask

  task automatic test_rx_pop();
    logic [DATA_W-1:0] rd;
    int lat, p0;
    p0 = rdnPulses;
    injectByte(8'hA5);
    waitRxCount(1);
    checkCnt++;
    if (rxCount !== 5'd1) $display("[TB] FAIL rx_count_one: got %0d expected 1", rxCount); else passCnt++;
    checkCnt++;
    if (rdnPulses - p0 !== 1 || rdnLast !== RAM_WAIT)
      $display("[TB] FAIL rx_rdn_strobe: pulses %0d width %0d expected 1 and %0d", rdnPulses - p0, rdnLast, RAM_WAIT);
    else passCnt++;
    doTxn(1'b0, DATA_ADDR, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== {8'h00, expRx[0]} || lat !== 1)
      $display("[TB] FAIL rx_pop_a5: got %h lat %0d expected %h lat 1", rd, lat, {8'h00, expRx[0]});
    else passCnt++;
    void'(expRx.pop_front());
    checkCnt++;
    if (rxCount !== 5'd0) $display("[TB] FAIL rx_count_zero: got %0d expected 0", rxCount); else passCnt++;
    for (int i = 0; i < 3; i++) injectByte(8'($urandom));
    waitRxCount(3);
    checkCnt++;
    if (rxCount !== 5'd3) $display("[TB] FAIL rx_count_three: got %0d expected 3", rxCount); else passCnt++;
    for (int i = 0; i < 3; i++) begin
      doTxn(1'b0, DATA_ADDR, 16'h0000, rd, lat);
      checkCnt++;
      if (rd !== {8'h00, expRx[0]}) $display("[TB] FAIL rx_rand_pop: got %h expected %h", rd, {8'h00, expRx[0]});
      else passCnt++;
      void'(expRx.pop_front());
    end
  endtask

  task automatic test_empty_read();
    logic [DATA_W-1:0] rd;
    int lat;
    doTxn(1'b0, DATA_ADDR, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== 16'h0000 || lat !== 1 || rxCount !== 5'd0)
      $display("[TB] FAIL rx_empty_read: rdata %h lat %0d count %0d expected 0000 1 0", rd, lat, rxCount);
    else passCnt++;
  endtask

  task automatic test_tx();
    logic [DATA_W-1:0] rd;
    int lat, t0;
    t0 = txCount;
    doTxn(1'b1, DATA_ADDR, 16'h0041, rd, lat);
    checkCnt++;
    if (txCount - t0 !== 1 || wrnLast !== RAM_WAIT)
      $display("[TB] FAIL tx_wrn_strobe: pulses %0d width %0d expected 1 and %0d", txCount - t0, wrnLast, RAM_WAIT);
    else passCnt++;
    checkCnt++;
    if (txByte !== 16'h0041) $display("[TB] FAIL tx_bus_data: got %h expected 0041", txByte); else passCnt++;
    // wrn rises 4 cycles after accept, tsre follows 8 cycles later, ack on the next edge
    checkCnt++;
    if (lat !== 13) $display("[TB] FAIL tx_ack_after_tsre: latency %0d expected 13", lat); else passCnt++;
  endtask

  task automatic test_fifo_full();
    logic [DATA_W-1:0] rd;
    int lat, p0, p1;
    p0 = rdnPulses;
    for (int i = 0; i < DEPTH + 4; i++) injectByte(8'($urandom));
    waitRxCount(DEPTH);
    repeat (6) @(negedge clk);
    checkCnt++;
    if (rxCount !== 5'(DEPTH) || rdnPulses - p0 !== DEPTH || dataReady !== 1'b1)
      $display("[TB] FAIL fifo_fill: count %0d pulses %0d data_ready %0d expected %0d %0d 1",
               rxCount, rdnPulses - p0, dataReady, DEPTH, DEPTH);
    else passCnt++;
    p1 = rdnPulses;
    doTxn(1'b0, 18'h00010, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== expMem[16] || rdnPulses !== p1)
      $display("[TB] FAIL full_ram_rd: rdata %h extra rdn %0d expected %h 0", rd, rdnPulses - p1, expMem[16]);
    else passCnt++;
    tbreForceLow = 1'b1;
    doTxn(1'b0, STAT_ADDR, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== 16'h0006) $display("[TB] FAIL stat_full_busy: got %h expected 0006", rd); else passCnt++;
    tbreForceLow = 1'b0;
    doTxn(1'b0, STAT_ADDR, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== 16'h0007) $display("[TB] FAIL stat_full_ready: got %h expected 0007", rd); else passCnt++;
    for (int i = 0; i < DEPTH + 4; i++) begin
      doTxn(1'b0, DATA_ADDR, 16'h0000, rd, lat);
      checkCnt++;
      if (rd !== {8'h00, expRx[0]}) $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, rd, {8'h00, expRx[0]});
      else passCnt++;
      void'(expRx.pop_front());
    end
    waitRxCount(0);
    checkCnt++;
    if (rxCount !== 5'd0 || dataReady !== 1'b0)
      $display("[TB] FAIL full_drained: count %0d data_ready %0d expected 0 0", rxCount, dataReady);
    else passCnt++;
  endtask

  task automatic test_reset_mid_tx();
    logic [DATA_W-1:0] rd, d;
    int lat;
    bit seen = 0;
    injectByte(8'($urandom)); injectByte(8'($urandom));
    waitRxCount(2);
    @(negedge clk);
    cpuBus.req = 1'b1; cpuBus.wr = 1'b1; cpuBus.addr = DATA_ADDR; cpuBus.wdata = 16'h0041;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (!wrn) seen = 1;
    end
    checkCnt++;
    if (!seen) $display("[TB] FAIL mid_tx_strobe_seen: wrn %0d expected 0 within 30 cycles", wrn);
    else passCnt++;
    #2 rst = 1'b0;
    #1;
    checkCnt++;
    if ({cpuBus.ack, cpuBus.busy, wrn, ramEn} !== 4'b0011)
      $display("[TB] FAIL mid_tx_abort: ack/busy/wrn/en %b expected 0011", {cpuBus.ack, cpuBus.busy, wrn, ramEn});
    else passCnt++;
    checkCnt++;
    if (rxCount !== 5'd0) $display("[TB] FAIL mid_tx_rx_clear: got %0d expected 0", rxCount); else passCnt++;
    zProbe = 1'b1; #1;
    checkCnt++;
    if (ramData !== 16'h0000) $display("[TB] FAIL mid_tx_bus_z: bus %h expected undriven", ramData); else passCnt++;
    zProbe = 1'b0;
    cpuBus.req = 1'b0;
    expRx.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d = 16'($urandom);
    doTxn(1'b1, 18'h00055, d, rd, lat);
    doTxn(1'b0, 18'h00055, 16'h0000, rd, lat);
    checkCnt++;
    if (rd !== d || lat !== 3) $display("[TB] FAIL post_reset_txn: got %h lat %0d expected %h lat 3", rd, lat, d);
    else passCnt++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cpuBus.req = 1'b0; cpuBus.wr = 1'b0; cpuBus.addr = '0; cpuBus.wdata = '0;
    test_reset();
    test_ram_write_read();
    test_rx_pop();
    test_empty_read();
    test_tx();
    test_fifo_full();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/ram_uart_ctrl.md
Name: ram_uart_ctrl

Overview:
- Parametrised controller for the shared RAM1/UART data bus.
- Serves CPU memory requests over a req/ack handshake: RAM1 read/write, UART TX, and UART RX pop from an internal FIFO; it also serves a UART status register.
- Opportunistically drains the UART receiver into the RX FIFO.
- Sits between the MEM stage and the board pins. Replaces the act-counter handshake with an explicit single-cycle ack.

Parameters:
- ADDR_W, 18: address width.
- DATA_W, 16: data bus width; must be ≥ 8.
- FIFO_LOG2, 4: RX FIFO depth = 2**FIFO_LOG2 entries.
- RAM_WAIT, 2: cycles OE/WE/rdn are held low per access, ≥ 1.
- UART_DATA_ADDR, 'hBF00: UART data register address.
- UART_STAT_ADDR, 'hBF01: UART status register address.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- req, in, 1: request valid, level. Requester holds addr/wr/wdata stable until ack.
- wr, in, 1: 1 = write, 0 = read.
- addr, in, ADDR_W: request address.
- wdata, in, DATA_W: write data.
- ack, out, 1: one-cycle pulse, transaction complete; rdata valid in the same cycle.
- rdata, out, DATA_W: read result, held until the next ack.
- busy, out, 1: FSM not in IDLE.
- ram_addr, out, ADDR_W: registered address to RAM1.
- ram_data, inout, DATA_W: shared RAM1/UART data bus.
- ram_en, out, 1: RAM1 chip enable, active-low.
- ram_oe, out, 1: RAM1 output enable, active-low.
- ram_we, out, 1: RAM1 write enable, active-low.
- rdn, out, 1: UART read strobe, active-low.
- wrn, out, 1: UART write strobe, active-low.
- data_ready, in, 1: UART has an RX byte.
- tbre, in, 1: UART transmit buffer empty.
- tsre, in, 1: UART transmit shift register empty.
- rx_count, out, FIFO_LOG2+1: RX FIFO occupancy.

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - FSM=IDLE; ram_en/ram_oe/ram_we/rdn/wrn=1; ack=0; rdata=0; ram_addr=0; bus high-Z.
  - FIFO pointers=0, rx_count=0. Any in-flight transaction is abandoned with no ack.
- Bus drive: ram_data is driven only in RAM_WR*, TX_SETUP, TX_STROBE and TX_HOLD; high-Z in every other state.
- ram_en=0 only in RAM states; ram_en=1 during all UART states.
- IDLE arbitration, evaluated every cycle:
  - 1) data_ready=1 and FIFO not full -> RX_STROBE.
  - 2) else req=1: latch addr into ram_addr and wdata, then decode:
    - addr==UART_STAT_ADDR -> RESP.
    - addr==UART_DATA_ADDR, wr -> TX_SETUP.
    - addr==UART_DATA_ADDR, !wr -> RESP (pop).
    - otherwise wr -> RAM_WR; !wr -> RAM_RD.
  - FIFO full: RX is deferred; the UART keeps the byte (back-pressure) and data_ready is not consumed.
- RX_STROBE: rdn=0 for RAM_WAIT cycles. On the last cycle, write ram_data[7:0] zero-extended to DATA_W at the tail. -> RX_DONE.
- RX_DONE: rdn=1, tail+1 mod depth, rx_count+1 -> IDLE.
- RAM_RD: ram_oe=0 for RAM_WAIT cycles; capture ram_data into rdata on the last cycle -> RESP.
- RAM_WR: ram_we=0 for RAM_WAIT cycles -> RAM_WR_HOLD.
- RAM_WR_HOLD: ram_we=1, data still driven (hold time) -> RESP.
- TX_SETUP: data driven, wrn=1, 1 cycle -> TX_STROBE.
- TX_STROBE: wrn=0 for RAM_WAIT cycles -> TX_HOLD.
- TX_HOLD: wrn=1, 1 cycle -> TX_WAIT_TBRE.
- TX_WAIT_TBRE: wait until tbre=1 -> TX_WAIT_TSRE.
- TX_WAIT_TSRE: wait until tsre=1 -> RESP. No timeout.
- RESP: ack=1 for exactly this cycle -> IDLE.
  - Status read: rdata = {0..., rx_full, rx_nonempty, tbre&tsre} in bits [2:0].
  - Data read, FIFO nonempty: rdata = queue[head]; head+1, rx_count-1.
  - Data read, FIFO empty: rdata=0, no pop, still acks.
  - Writes to UART_STAT_ADDR are acked and ignored.
- Latency, IDLE accept to ack:
  - RAM read: RAM_WAIT+1.
  - RAM write: RAM_WAIT+2.
  - Status / UART data read: 1.
  - TX: RAM_WAIT+3 plus the tbre/tsre wait.
  - A pending RX drain adds RAM_WAIT+1 before the request is accepted.
- req still high in the cycle after ack is treated as a new transaction; the requester must drop req or change it on ack.
- Push and pop never occur in the same cycle (single FSM), so rx_count is exact.
- Pointers wrap mod 2**FIFO_LOG2. rx_count saturates at the depth by construction, since full blocks RX.
- Illegal/unused state encodings -> IDLE with all strobes deasserted.

Decomposition:
- Shared package/include: FSM state encodings, UART_DATA_ADDR/UART_STAT_ADDR defaults, status bit positions (STAT_TXRDY=0, STAT_RXAV=1, STAT_RXFULL=2).
- One sub-module: rx_fifo, a synchronous FIFO with parameters DATA_W and FIFO_LOG2.
  - Ports: push, pop, din, dout, count, full, empty.
  - Async active-low reset.

Test Plan:
- RAM write 'h1234 @'h00010, then read @'h00010 (RAM_WAIT=2): ram_we low exactly 2 cycles; ack 4 cycles after accept; read acks after 3 cycles with rdata='h1234; bus high-Z during the read.
- Pulse data_ready with UART byte 'hA5, then read UART_DATA_ADDR: rdn low 2 cycles, rx_count=1; read returns 'h00A5 and rx_count=0.
- Read UART_DATA_ADDR with FIFO empty: ack after 1 cycle, rdata=0, rx_count stays 0.
- Write 'h0041 to UART_DATA_ADDR with tbre delayed 5 cycles and tsre 3 more: wrn low 2 cycles with bus='h0041; ack only after tsre=1.
- Fill FIFO with 16 bytes, hold data_ready=1, issue a RAM read: no 17th rdn strobe; RAM read serviced; status read gives bits[2:0]=3'b110 (rx_full, rx_nonempty, tbre&tsre=0 at the time of the read) with the UART models' tbre=0, or 3'b111 with tbre=tsre=1.
- Assert rst=0 mid-TX_STROBE: wrn=1, bus high-Z and ack=0 immediately; rx_count=0; the next transaction after release completes normally.
